spi_master_ctrl: RTL and testbench

SPI master controller (mode 0: CPOL=0, CPHA=0, MSB first) that sequences byte transfers on the system clock domain. It generates SCLK from clk, drives CS_n and frames multi-byte transactions. It shifts TX bytes out on MOSI and assembles RX bytes from MISO. Upstream logic feeds it through a valid/ready byte stream with a last flag; it sits between the command/data source and the SPI pins.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_half_timer.sv | 30 +++
 rtl/spi_master_ctrl.sv | 124 ++++++++++++
 tb/tb_spi_master_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// SPI master shared types and constants.
// State encoding and byte/bit-counter sizing.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      WAIT_NEXT,
      HOLD,
      GAP
   } spi_state_e;

   localparam int SPI_BYTE_BITS = 8;
   localparam int SPI_CNT_W     = $clog2(SPI_BYTE_BITS);

endpackage

// File: rtl/spi_half_timer.sv
// Half-period down-counter for SPI phase timing.
// expire is high on the last cycle of a timed phase.
module spi_half_timer #(
   parameter int HALF_PERIOD = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic expire
);

   localparam int W = $clog2(HALF_PERIOD + 1);
   localparam logic [W-1:0] RELOAD = W'(HALF_PERIOD - 1);

   logic [W-1:0] cnt;

   // reload on phase entry, then count down and rest at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= RELOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: frames byte streams onto sclk/mosi/cs_n.
// MSB first; miso sampled on the rising sclk update.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int HALF_PERIOD = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n
);

   if (HALF_PERIOD < 1) begin : g_bad_half_period
      $error("spi_master_ctrl: HALF_PERIOD must be >= 1");
   end

   localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_BYTE_BITS - 1);

   spi_state_e           state;
   logic [7:0]           tx_sr;
   logic [7:0]           rx_sr;
   logic [SPI_CNT_W-1:0] bit_cnt;
   logic                 last_q;
   logic                 accept;
   logic                 timed;
   logic                 expire;
   logic                 start;

   assign tx_ready = !rst && (state == IDLE || state == WAIT_NEXT);
   assign accept   = tx_valid && tx_ready;
   assign timed    = state inside {SETUP, HIGH, LOW, HOLD, GAP};
   assign start    = accept || (timed && expire);
   assign busy     = (state != IDLE);
   assign mosi     = tx_sr[7];

   spi_half_timer #(
      .HALF_PERIOD(HALF_PERIOD)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .expire(expire)
   );

   // frame sequencer: phases, shift registers and pin outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cs_n     <= 1'b1;
         sclk     <= 1'b0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         bit_cnt  <= '0;
         last_q   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  tx_sr   <= tx_data;
                  last_q  <= tx_last;
                  bit_cnt <= '0;
                  cs_n    <= 1'b0;
                  state   <= SETUP;
               end
            end
            SETUP, LOW: begin
               if (expire) begin
                  sclk  <= 1'b1;
                  rx_sr <= {rx_sr[6:0], miso};
                  state <= HIGH;
               end
            end
            HIGH: begin
               if (expire) begin
                  sclk <= 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     rx_data  <= rx_sr;
                     rx_valid <= 1'b1;
                     state    <= last_q ? HOLD : WAIT_NEXT;
                  end else begin
                     tx_sr   <= {tx_sr[6:0], 1'b0};
                     bit_cnt <= bit_cnt + SPI_CNT_W'(1);
                     state   <= LOW;
                  end
               end
            end
            WAIT_NEXT: begin
               if (accept) begin
                  tx_sr   <= tx_data;
                  last_q  <= tx_last;
                  bit_cnt <= '0;
                  state   <= LOW;
               end
            end
            HOLD: begin
               if (expire) begin
                  cs_n  <= 1'b1;
                  state <= GAP;
               end
            end
            GAP: begin
               if (expire) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl (HALF_PERIOD 2 and 1).
// Bit-stream/byte-stream reference model with slave or loopback miso.
module tb_spi_master_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       sel = 1'b0;
   logic       miso;

   logic       tx_ready0, rx_valid0, busy0, sclk0, mosi0, cs_n0;
   logic       tx_ready1, rx_valid1, busy1, sclk1, mosi1, cs_n1;
   logic [7:0] rx_data0, rx_data1;

   logic       m_tx_ready, m_rx_valid, m_busy, m_sclk, m_mosi, m_cs_n;
   logic [7:0] m_rx_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spi_master_ctrl #(.HALF_PERIOD(2)) dut0 (
      .clk(clk), .rst(rst), .tx_data(tx_data),
      .tx_valid(tx_valid && !sel), .tx_last(tx_last),
      .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
      .busy(busy0), .sclk(sclk0), .mosi(mosi0), .miso(miso), .cs_n(cs_n0)
   );

   spi_master_ctrl #(.HALF_PERIOD(1)) dut1 (
      .clk(clk), .rst(rst), .tx_data(tx_data),
      .tx_valid(tx_valid && sel), .tx_last(tx_last),
      .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1),
      .busy(busy1), .sclk(sclk1), .mosi(mosi1), .miso(miso), .cs_n(cs_n1)
   );

   assign m_tx_ready = sel ? tx_ready1 : tx_ready0;
   assign m_rx_valid = sel ? rx_valid1 : rx_valid0;
   assign m_rx_data  = sel ? rx_data1  : rx_data0;
   assign m_busy     = sel ? busy1     : busy0;
   assign m_sclk     = sel ? sclk1     : sclk0;
   assign m_mosi     = sel ? mosi1     : mosi0;
   assign m_cs_n     = sel ? cs_n1     : cs_n0;

   // slave model: presents slave_bytes MSB first, advancing after each rise
   logic       loop_mode = 1'b1;
   logic [7:0] slave_bytes [4];
   int         rise_cnt = 0;
   logic       slave_bit;

   always_comb begin
      int b;
      b = rise_cnt / 8;
      if (b > 3) b = 3;
      slave_bit = slave_bytes[b][7 - (rise_cnt % 8)];
   end

   assign miso = loop_mode ? m_mosi : slave_bit;

   // monitors
   logic       mosi_q [$];
   logic [7:0] rx_q [$];
   int cyc = 0, cs_low = 0, gap_cnt = 0, acc_cnt = 0, cs_falls = 0;
   int high_run = 0, last_gap = 0, fall_cyc = 0, first_rise_d = -1;
   int prev_rise = -1, per_min = 1000, per_max = 0;
   logic cs_prev = 1'b1, sclk_prev = 1'b0;

   always @(posedge clk) cyc++;

   always @(posedge m_sclk) begin
      mosi_q.push_back(m_mosi);
      rise_cnt++;
   end

   always @(negedge clk) begin
      if (m_rx_valid) rx_q.push_back(m_rx_data);
      if (!m_cs_n) cs_low++;
      if (m_cs_n && m_busy) gap_cnt++;
      if (m_tx_ready && tx_valid) acc_cnt++;
      if (m_cs_n) high_run++;
      else begin
         if (high_run > 0) last_gap = high_run;
         high_run = 0;
      end
      if (!m_cs_n && cs_prev) begin
         cs_falls++;
         fall_cyc = cyc;
      end
      if (m_sclk && !sclk_prev) begin
         if (first_rise_d < 0) first_rise_d = cyc - fall_cyc;
         if (prev_rise >= 0) begin
            if (cyc - prev_rise < per_min) per_min = cyc - prev_rise;
            if (cyc - prev_rise > per_max) per_max = cyc - prev_rise;
         end
         prev_rise = cyc;
      end
      cs_prev = m_cs_n;
      sclk_prev = m_sclk;
   end

   task automatic clear_mon();
      mosi_q.delete();
      rx_q.delete();
      rise_cnt = 0; cs_low = 0; gap_cnt = 0; acc_cnt = 0; cs_falls = 0;
      first_rise_d = -1; prev_rise = -1; per_min = 1000; per_max = 0;
   endtask

   // reference model: serial stream is the bytes concatenated MSB first
   function automatic logic [63:0] pack_bytes(input logic [7:0] q [$]);
      logic [63:0] v = '0;
      foreach (q[i]) v = {v[55:0], q[i]};
      return v;
   endfunction

   function automatic logic [63:0] pack_bits();
      logic [63:0] v = '0;
      foreach (mosi_q[i]) v = {v[62:0], mosi_q[i]};
      return v;
   endfunction

   task automatic send(input logic [7:0] d, input logic l);
      int n = 0;
      @(posedge clk); #1;
      tx_data = d; tx_last = l; tx_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!m_tx_ready && n < 2000);
      checks++;
      if (!m_tx_ready) begin
         failures++;
         $display("FAIL send_ready got=0 exp=1 byte=%h", d);
      end
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_busy && n < 5000);
      checks++;
      if (m_busy) begin
         failures++;
         $display("FAIL wait_idle busy got=1 exp=0");
      end
   endtask

   task automatic test_reset();
      logic [13:0] got;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      got = {cs_n0, sclk0, mosi0, rx_valid0, tx_ready0, busy0, rx_data0};
      checks++;
      if (got !== 14'b10_0000_0000_0000) begin
         failures++;
         $display("FAIL reset_state got=%b exp=%b", got, 14'b10_0000_0000_0000);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (tx_ready0 !== 1'b1 || tx_ready1 !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready got=%b%b exp=11", tx_ready0, tx_ready1);
      end
   endtask

   task automatic test_single();
      logic [7:0] sent [$];
      loop_mode = 1'b1;
      clear_mon();
      sent.push_back(8'hA5);
      send(8'hA5, 1'b1);
      wait_idle();
      checks++;
      if (mosi_q.size() != 8 || pack_bits() !== pack_bytes(sent)) begin
         failures++;
         $display("FAIL single_mosi got=%h n=%0d exp=%h", pack_bits(), mosi_q.size(), pack_bytes(sent));
      end
      checks++;
      if (cs_low != 34) begin
         failures++;
         $display("FAIL single_cs_low got=%0d exp=34", cs_low);
      end
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
         failures++;
         $display("FAIL single_rx got=%h n=%0d exp=a5", pack_bytes(rx_q), rx_q.size());
      end
      checks++;
      if (gap_cnt != 2 || m_tx_ready !== 1'b1) begin
         failures++;
         $display("FAIL single_gap got=%0d rdy=%b exp=2 rdy=1", gap_cnt, m_tx_ready);
      end
      checks++;
      if (first_rise_d != 2 || per_min != 4 || per_max != 4) begin
         failures++;
         $display("FAIL single_sclk_timing got=%0d/%0d/%0d exp=2/4/4", first_rise_d, per_min, per_max);
      end
   endtask

   task automatic test_two_byte();
      logic [7:0] sent [$];
      logic [7:0] exp_rx [$];
      loop_mode = 1'b0;
      slave_bytes[0] = 8'h5A; slave_bytes[1] = 8'h96;
      slave_bytes[2] = 8'h00; slave_bytes[3] = 8'h00;
      clear_mon();
      sent = '{8'h3C, 8'hC3};
      exp_rx = '{8'h5A, 8'h96};
      send(8'h3C, 1'b0);
      send(8'hC3, 1'b1);
      wait_idle();
      checks++;
      if (mosi_q.size() != 16 || pack_bits() !== pack_bytes(sent)) begin
         failures++;
         $display("FAIL two_mosi got=%h n=%0d exp=%h", pack_bits(), mosi_q.size(), pack_bytes(sent));
      end
      checks++;
      if (cs_falls != 1) begin
         failures++;
         $display("FAIL two_cs_frames got=%0d exp=1", cs_falls);
      end
      checks++;
      if (rx_q.size() != 2 || pack_bytes(rx_q) !== pack_bytes(exp_rx)) begin
         failures++;
         $display("FAIL two_rx got=%h exp=%h", pack_bytes(rx_q), pack_bytes(exp_rx));
      end
   endtask

   task automatic test_wait_next();
      logic [7:0] sent [$];
      logic [7:0] b1, b2;
      int n = 0;
      int bad = 0;
      loop_mode = 1'b1;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      sent = '{b1, b2};
      clear_mon();
      send(b1, 1'b0);
      do begin
         @(negedge clk);
         n++;
      end while (!m_tx_ready && n < 500);
      for (int i = 0; i < 10; i++) begin
         if (m_sclk !== 1'b0 || m_cs_n !== 1'b0 || m_tx_ready !== 1'b1 || m_busy !== 1'b1)
            bad++;
         if (i < 9) @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL wait_next_hold got=%0d bad cycles exp=0", bad);
      end
      send(b2, 1'b1);
      wait_idle();
      checks++;
      if (mosi_q.size() != 16 || pack_bits() !== pack_bytes(sent)) begin
         failures++;
         $display("FAIL wait_next_mosi got=%h exp=%h", pack_bits(), pack_bytes(sent));
      end
      checks++;
      if (rx_q.size() != 2 || pack_bytes(rx_q) !== pack_bytes(sent)) begin
         failures++;
         $display("FAIL wait_next_rx got=%h exp=%h", pack_bytes(rx_q), pack_bytes(sent));
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] sent [$];
      int n = 0;
      loop_mode = 1'b1;
      clear_mon();
      send(8'hFF, 1'b1);
      do begin
         @(negedge clk);
         n++;
      end while (rise_cnt < 3 && n < 500);
      rst = 1'b1;
      #1;
      checks++;
      if ({m_cs_n, m_sclk, m_mosi, m_busy} !== 4'b1000) begin
         failures++;
         $display("FAIL midframe_reset got=%b exp=1000", {m_cs_n, m_sclk, m_mosi, m_busy});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (rx_q.size() != 0) begin
         failures++;
         $display("FAIL midframe_no_rx got=%0d exp=0", rx_q.size());
      end
      clear_mon();
      sent.push_back(8'h81);
      send(8'h81, 1'b1);
      wait_idle();
      checks++;
      if (mosi_q.size() != 8 || pack_bits() !== pack_bytes(sent) ||
          rx_q.size() != 1 || rx_q[0] !== 8'h81) begin
         failures++;
         $display("FAIL midframe_after got=%h rx=%h exp=81", pack_bits(), pack_bytes(rx_q));
      end
   endtask

   task automatic test_hold_valid();
      logic [7:0] sent [$];
      logic [7:0] d2;
      int n = 0;
      loop_mode = 1'b1;
      clear_mon();
      @(posedge clk); #1;
      tx_data = 8'h6B; tx_last = 1'b1; tx_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!m_tx_ready && n < 500);
      n = 0;
      do begin
         @(posedge clk); #1;
         tx_data = 8'($urandom);
         @(negedge clk);
         n++;
      end while (!m_tx_ready && n < 500);
      d2 = tx_data;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      wait_idle();
      sent = '{8'h6B, d2};
      checks++;
      if (acc_cnt != 2) begin
         failures++;
         $display("FAIL hold_accepts got=%0d exp=2", acc_cnt);
      end
      checks++;
      if (mosi_q.size() != 16 || pack_bits() !== pack_bytes(sent)) begin
         failures++;
         $display("FAIL hold_mosi got=%h exp=%h", pack_bits(), pack_bytes(sent));
      end
      checks++;
      if (cs_falls != 2 || last_gap < 2) begin
         failures++;
         $display("FAIL hold_cs_gap got=%0d falls=%0d exp>=2 falls=2", last_gap, cs_falls);
      end
   endtask

   task automatic test_random();
      logic [7:0] sent [$];
      logic [7:0] exp_rx [$];
      logic [7:0] b;
      int nb;
      for (int it = 0; it < 4; it++) begin
         nb = $urandom_range(1, 3);
         loop_mode = 1'($urandom_range(0, 1));
         for (int k = 0; k < 4; k++) slave_bytes[k] = 8'($urandom);
         sent.delete();
         exp_rx.delete();
         clear_mon();
         for (int k = 0; k < nb; k++) begin
            b = 8'($urandom);
            sent.push_back(b);
            exp_rx.push_back(loop_mode ? b : slave_bytes[k]);
            send(b, k == nb - 1);
         end
         wait_idle();
         checks++;
         if (mosi_q.size() != 8 * nb || pack_bits() !== pack_bytes(sent)) begin
            failures++;
            $display("FAIL rand_mosi it=%0d got=%h exp=%h", it, pack_bits(), pack_bytes(sent));
         end
         checks++;
         if (rx_q.size() != nb || pack_bytes(rx_q) !== pack_bytes(exp_rx) || cs_falls != 1) begin
            failures++;
            $display("FAIL rand_rx it=%0d got=%h exp=%h", it, pack_bytes(rx_q), pack_bytes(exp_rx));
         end
      end
   endtask

   task automatic test_hp1();
      sel = 1'b1;
      loop_mode = 1'b1;
      repeat (2) @(negedge clk);
      clear_mon();
      send(8'h5A, 1'b1);
      wait_idle();
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
         failures++;
         $display("FAIL hp1_rx got=%h exp=5a", pack_bytes(rx_q));
      end
      checks++;
      if (rise_cnt != 8 || cs_low != 17 || per_min != 2 || per_max != 2 || first_rise_d != 1) begin
         failures++;
         $display("FAIL hp1_timing got=%0d/%0d/%0d/%0d/%0d exp=8/17/2/2/1",
                  rise_cnt, cs_low, per_min, per_max, first_rise_d);
      end
      sel = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) slave_bytes[k] = '0;
      test_reset();
      test_single();
      test_two_byte();
      test_wait_next();
      test_reset_midframe();
      test_hold_valid();
      test_random();
      test_hp1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
